// File: rtl/register_bank_arbiter.sv
// register_bank_arbiter
//   Routes operand-collector reads and the writeback stream onto NumBanks
//   single-port register file banks, then routes bank read responses back
//   to the requester that issued them.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_valid_i/ready_o      per-requester read handshake
//   req_addr_i, req_tag_i    per-requester register index and tag
//   wb_valid_i/ready_o       writeback handshake
//   wb_addr_i/mask_i/data_i  writeback register index, lane mask, warp data
//   bank_read_*              per-bank read port (row + {requester id, tag})
//   bank_write_*             per-bank write valid/ready/row, broadcast mask/data
//   bank_rsp_*               per-bank read response (tag + data)
//   rsp_*                    per-requester read response
//
// Each bank's read slot is granted round-robin among the requesters
// addressing it. A per-bank counter tracks how many consecutive writes have
// stolen the bank from a waiting read; at StarveLimit the writes to that
// bank are held off so the read gets through. All outputs are combinational
// and no valid output depends on any ready input.

module register_bank_arbiter #(
  parameter int unsigned NumRequesters = 4,
  parameter int unsigned NumBanks      = 4,
  parameter int unsigned NumRegisters  = 128,
  parameter int unsigned WarpWidth     = 8,
  parameter int unsigned RegisterWidth = 32,
  parameter int unsigned StarveLimit   = 4,
  parameter type         tag_t         = logic,
  localparam int unsigned IdW      = (NumRequesters > 1) ? $clog2(NumRequesters) : 1,
  localparam int unsigned TagW     = $bits(tag_t),
  localparam int unsigned BTagW    = IdW + TagW,
  localparam int unsigned AddrW    = (NumRegisters > 1) ? $clog2(NumRegisters) : 1,
  localparam int unsigned BankBits = $clog2(NumBanks),
  localparam int unsigned BankW    = (NumBanks > 1) ? BankBits : 1,
  localparam int unsigned RowW     = (AddrW > BankBits) ? (AddrW - BankBits) : 1,
  localparam int unsigned DataW    = WarpWidth * RegisterWidth,
  localparam int unsigned StallW   = (StarveLimit > 0) ? $clog2(StarveLimit + 1) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NumRequesters-1:0]               req_valid_i,
  output logic [NumRequesters-1:0]               req_ready_o,
  input  logic [NumRequesters-1:0][AddrW-1:0]    req_addr_i,
  input  logic [NumRequesters-1:0][TagW-1:0]     req_tag_i,
  input  logic                                   wb_valid_i,
  output logic                                   wb_ready_o,
  input  logic [AddrW-1:0]                       wb_addr_i,
  input  logic [WarpWidth-1:0]                   wb_mask_i,
  input  logic [DataW-1:0]                       wb_data_i,
  output logic [NumBanks-1:0]                    bank_read_valid_o,
  input  logic [NumBanks-1:0]                    bank_read_ready_i,
  output logic [NumBanks-1:0][RowW-1:0]          bank_read_addr_o,
  output logic [NumBanks-1:0][BTagW-1:0]         bank_read_tag_o,
  output logic [NumBanks-1:0]                    bank_write_valid_o,
  input  logic [NumBanks-1:0]                    bank_write_ready_i,
  output logic [NumBanks-1:0][RowW-1:0]          bank_write_addr_o,
  output logic [WarpWidth-1:0]                   bank_write_mask_o,
  output logic [DataW-1:0]                       bank_write_data_o,
  input  logic [NumBanks-1:0]                    bank_rsp_valid_i,
  input  logic [NumBanks-1:0][BTagW-1:0]         bank_rsp_tag_i,
  input  logic [NumBanks-1:0][DataW-1:0]         bank_rsp_data_i,
  output logic [NumRequesters-1:0]               rsp_valid_o,
  output logic [NumRequesters-1:0][TagW-1:0]     rsp_tag_o,
  output logic [NumRequesters-1:0][DataW-1:0]    rsp_data_o
);

  // Low index bits select the bank (NumBanks is a power of two).
  function automatic logic [BankW-1:0] bank_of(input logic [AddrW-1:0] addr);
    return BankW'(addr & AddrW'(NumBanks - 1));
  endfunction

  // Remaining high index bits select the row within the bank.
  function automatic logic [RowW-1:0] row_of(input logic [AddrW-1:0] addr);
    return RowW'(addr >> BankBits);
  endfunction

  // Requester index `base + k`, wrapped modulo NumRequesters.
  function automatic logic [IdW-1:0] wrap_add(input logic [IdW-1:0] base, input int k);
    int s;
    s = (int'(base) + k) % int'(NumRequesters);
    return IdW'(s);
  endfunction

  logic [NumRequesters-1:0][BankW-1:0]    req_bank_s;
  logic [NumRequesters-1:0][RowW-1:0]     req_row_s;
  logic [NumBanks-1:0][NumRequesters-1:0] cand_s;
  logic [NumBanks-1:0][IdW-1:0]           winner_s;
  logic [IdW-1:0]                         idx_s;
  logic [NumBanks-1:0]                    read_hs_s;
  logic [NumBanks-1:0]                    block_s;
  logic [NumBanks-1:0]                    write_acc_s;
  logic [BankW-1:0]                       wb_bank_s;
  logic [RowW-1:0]                        wb_row_s;
  logic [NumBanks-1:0][IdW-1:0]           rr_r;
  logic [NumBanks-1:0][StallW-1:0]        stall_r;

  // Decode every request into bank/row and build each bank's candidate set.
  always_comb begin
    req_bank_s = '0;
    req_row_s  = '0;
    cand_s     = '0;
    for (int r = 0; r < int'(NumRequesters); r++) begin
      req_bank_s[r] = bank_of(req_addr_i[r]);
      req_row_s[r]  = row_of(req_addr_i[r]);
      for (int b = 0; b < int'(NumBanks); b++) begin
        if (req_valid_i[r] && (req_bank_s[r] == BankW'(b))) begin
          cand_s[b][r] = 1'b1;
        end else begin
          cand_s[b][r] = 1'b0;
        end
      end
    end
  end

  // Round-robin pick per bank. Scanning offsets from high to low lets the
  // smallest offset from the pointer overwrite any later candidate.
  always_comb begin
    winner_s          = '0;
    idx_s             = '0;
    bank_read_valid_o = '0;
    bank_read_addr_o  = '0;
    bank_read_tag_o   = '0;
    read_hs_s         = '0;
    for (int b = 0; b < int'(NumBanks); b++) begin
      for (int k = int'(NumRequesters) - 1; k >= 0; k--) begin
        idx_s = wrap_add(rr_r[b], k);
        if (cand_s[b][idx_s]) begin
          winner_s[b] = idx_s;
        end else begin
          winner_s[b] = winner_s[b];
        end
      end
      bank_read_valid_o[b] = |cand_s[b];
      if (bank_read_valid_o[b]) begin
        bank_read_addr_o[b] = req_row_s[winner_s[b]];
        bank_read_tag_o[b]  = {winner_s[b], req_tag_i[winner_s[b]]};
      end else begin
        bank_read_addr_o[b] = '0;
        bank_read_tag_o[b]  = '0;
      end
      read_hs_s[b] = bank_read_valid_o[b] & bank_read_ready_i[b];
    end
  end

  // A requester is ready only when it won its bank and that bank accepts.
  always_comb begin
    req_ready_o = '0;
    for (int r = 0; r < int'(NumRequesters); r++) begin
      req_ready_o[r] = req_valid_i[r]
                     && (winner_s[req_bank_s[r]] == IdW'(r))
                     && bank_read_ready_i[req_bank_s[r]];
    end
  end

  // Writeback steering; a bank whose read has starved refuses the write.
  always_comb begin
    wb_bank_s          = bank_of(wb_addr_i);
    wb_row_s           = row_of(wb_addr_i);
    block_s            = '0;
    bank_write_valid_o = '0;
    bank_write_addr_o  = '0;
    write_acc_s        = '0;
    for (int b = 0; b < int'(NumBanks); b++) begin
      block_s[b]            = (StarveLimit != 0) && (stall_r[b] == StallW'(StarveLimit));
      bank_write_valid_o[b] = wb_valid_i && (wb_bank_s == BankW'(b)) && !block_s[b];
      bank_write_addr_o[b]  = wb_row_s;
      write_acc_s[b]        = bank_write_valid_o[b] && bank_write_ready_i[b];
    end
    wb_ready_o = bank_write_ready_i[wb_bank_s] && !block_s[wb_bank_s];
  end

  assign bank_write_mask_o = wb_mask_i;
  assign bank_write_data_o = wb_data_i;

  // Round-robin pointers advance past the winner on a read handshake;
  // starvation counters count writes that beat a pending read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_r    <= '0;
      stall_r <= '0;
    end else begin
      for (int b = 0; b < int'(NumBanks); b++) begin
        if (read_hs_s[b]) begin
          rr_r[b] <= (winner_s[b] == IdW'(NumRequesters - 1)) ? '0 : (winner_s[b] + IdW'(1));
        end else begin
          rr_r[b] <= rr_r[b];
        end
        if (read_hs_s[b] || !bank_read_valid_o[b]) begin
          stall_r[b] <= '0;
        end else if (write_acc_s[b] && (stall_r[b] != StallW'(StarveLimit))) begin
          stall_r[b] <= stall_r[b] + StallW'(1);
        end else begin
          stall_r[b] <= stall_r[b];
        end
      end
    end
  end

  // Route each bank response to the requester named in its tag's id field.
  always_comb begin
    rsp_valid_o = '0;
    rsp_tag_o   = '0;
    rsp_data_o  = '0;
    for (int r = 0; r < int'(NumRequesters); r++) begin
      for (int b = 0; b < int'(NumBanks); b++) begin
        if (bank_rsp_valid_i[b] && (bank_rsp_tag_i[b][BTagW-1 -: IdW] == IdW'(r))) begin
          rsp_valid_o[r] = 1'b1;
          rsp_tag_o[r]   = bank_rsp_tag_i[b][TagW-1:0];
          rsp_data_o[r]  = bank_rsp_data_i[b];
        end else begin
          rsp_valid_o[r] = rsp_valid_o[r];
        end
      end
    end
  end

  register_bank_arbiter_checker #(
    .NumRequesters (NumRequesters),
    .NumBanks      (NumBanks),
    .IdW           (IdW),
    .BTagW         (BTagW)
  ) u_checker (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .bank_rsp_valid_i (bank_rsp_valid_i),
    .bank_rsp_tag_i   (bank_rsp_tag_i)
  );

endmodule

// register_bank_arbiter_checker
//   Flags a cycle in which two banks return a response to the same requester.
// Ports: clk_i, rst_ni, bank_rsp_valid_i, bank_rsp_tag_i (observed only).
module register_bank_arbiter_checker #(
  parameter int unsigned NumRequesters = 4,
  parameter int unsigned NumBanks      = 4,
  parameter int unsigned IdW           = 2,
  parameter int unsigned BTagW         = 3
) (
  input logic                          clk_i,
  input logic                          rst_ni,
  input logic [NumBanks-1:0]           bank_rsp_valid_i,
  input logic [NumBanks-1:0][BTagW-1:0] bank_rsp_tag_i
);

  logic [NumRequesters-1:0][NumBanks-1:0] match_s;
  logic [NumRequesters-1:0]               multi_s;

  // Per requester, which banks respond to it and whether more than one does.
  always_comb begin
    match_s = '0;
    multi_s = '0;
    for (int r = 0; r < int'(NumRequesters); r++) begin
      for (int b = 0; b < int'(NumBanks); b++) begin
        match_s[r][b] = bank_rsp_valid_i[b] && (bank_rsp_tag_i[b][BTagW-1 -: IdW] == IdW'(r));
      end
      multi_s[r] = ($countones(match_s[r]) > 1);
    end
  end

  a_single_rsp_per_requester : assert property (
    @(posedge clk_i) disable iff (!rst_ni) (multi_s == '0)
  ) else $error("two bank responses target one requester in the same cycle");

endmodule

// File: doc/register_bank_arbiter.md
# register_bank_arbiter

Sits between the operand collectors / writeback unit and the `NumBanks` single-port register file banks of a compute unit. It decodes each register index into bank and row, grants each bank's single read slot round-robin among the read requesters, and forwards the writeback stream to the addressed bank. A per-bank starvation counter holds off writes so that reads make progress, and bank read responses are routed back to the issuing requester.

## Interface
- `NumRequesters`, 4: read requesters (operand collectors); ≥1.
- `NumBanks`, 4: register banks; power of two, ≥1.
- `NumRegisters`, 128: total registers; multiple of `NumBanks`.
- `WarpWidth`, 8; `RegisterWidth`, 32: bank data shape.
- `StarveLimit`, 4: consecutive write-blocked cycles tolerated by a pending read; 0 disables the guard.
- `tag_t`, logic: requester tag; bank tag `btag_t` = {requester id (`$clog2(NumRequesters)` bits, min 1), `tag_t`}.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `req_valid_i` / `req_ready_o`, in / out, [NumRequesters]: read request handshakes.
- `req_addr_i`, in, [NumRequesters] x `$clog2(NumRegisters)`: register index.
- `req_tag_i`, in, [NumRequesters] x `tag_t`.
- `wb_valid_i` / `wb_ready_o`, in / out, 1: writeback handshake.
- `wb_addr_i` in `$clog2(NumRegisters)`; `wb_mask_i` in `WarpWidth`; `wb_data_i` in `WarpWidth*RegisterWidth`.
- `bank_read_valid_o` out [NumBanks]; `bank_read_ready_i` in [NumBanks]; `bank_read_addr_o` out [NumBanks] x row width; `bank_read_tag_o` out [NumBanks] x `btag_t`.
- `bank_write_valid_o` out [NumBanks]; `bank_write_ready_i` in [NumBanks]; `bank_write_addr_o` out [NumBanks] x row width; `bank_write_mask_o`, `bank_write_data_o` out, broadcast to all banks.
- `bank_rsp_valid_i` in [NumBanks]; `bank_rsp_tag_i` in [NumBanks] x `btag_t`; `bank_rsp_data_i` in [NumBanks] x warp data.
- `rsp_valid_o` out [NumRequesters]; `rsp_tag_o` out [NumRequesters] x `tag_t`; `rsp_data_o` out [NumRequesters] x warp data.

## Operation
- Address decode: bank = index[`$clog2(NumBanks)`-1:0]; row = index >> `$clog2(NumBanks)`. With `NumBanks`=1, bank = 0 and row = index.
- Read arbitration, per bank b:
  - Candidates are requesters with `req_valid_i` whose decoded bank is b.
  - Round-robin pointer `rr_q[b]`: the first candidate at or above the pointer wins, wrapping modulo `NumRequesters`.
  - `bank_read_valid_o[b]` = any candidate; row and `btag_t` come from the winner.
  - `req_ready_o[r]` = r is the winner of its bank AND `bank_read_ready_i[b]`.
  - On handshake, `rr_q[b]` ← winner+1 (wraps). Otherwise `rr_q[b]` holds.
- Write path:
  - `bank_write_valid_o[b]` = `wb_valid_i` AND (wb bank == b) AND !`block[b]`.
  - `wb_ready_o` = `bank_write_ready_i[wbbank]` AND !`block[wbbank]`.
  - Row is driven to every bank's `bank_write_addr_o`. Mask and data are broadcast.
- Starvation guard, per-bank counter `stall_q[b]`, width `$clog2(StarveLimit+1)`:
  - `block[b]` = (`StarveLimit`≠0) AND (`stall_q[b]` == `StarveLimit`).
  - Increment (saturating) when `bank_read_valid_o[b]` AND NOT read handshake AND a write to b is accepted.
  - Clear to 0 on a read handshake at b, or when b has no candidate.
  - Otherwise hold.
- Response routing:
  - `rsp_valid_o[r]` = OR over b of (`bank_rsp_valid_i[b]` AND id(`bank_rsp_tag_i[b]`) == r).
  - Tag and data come from the matching bank.
  - At most one bank matches per requester per cycle, because a requester issues ≤1 read per cycle at fixed bank latency. Two matches is an assertion error.
- Combinational-loop rule: valid outputs never depend on any ready input.

## Timing
- Reset (async, `rst_ni`=0): `rr_q` = 0 and `stall_q` = 0 for all banks.
- All outputs are combinational. With all valid inputs low, every valid/ready output is 0, except `wb_ready_o`, which follows `bank_write_ready_i[0]`.
- Request-to-bank latency: 0 cycles. Bank response to `rsp_*`: 0 cycles. End-to-end read latency equals the bank latency (1 cycle).
- Arbitration state updates on the rising edge after the handshake. Requesters must hold valid and payload until ready.
- Write and read to the same bank in the same cycle: the write passes unless blocked. The bank then withholds read ready, so the read retries.
- Reset mid-operation: pointers and counters return to 0. In-flight bank responses are still routed; they are combinational.

## Test plan
- Single read: req0 reads addr 5 (bank 1, row 1) with `bank_read_ready_i`=1 → `bank_read_valid_o[1]`=1, row 1, tag id 0. Inject a bank response one cycle later → `rsp_valid_o[0]`=1 with tag and data intact.
- Round-robin: all 4 requesters read bank 0 continuously with ready=1 → grant order 0,1,2,3,0 and `rr_q[0]` returns to 0.
- Parallel banks: requesters 0..3 read addrs 0,1,2,3 → all four `req_ready_o` are high in the same cycle.
- Starvation, `StarveLimit`=4: writes stream to bank 2 while req1 reads bank 2, and the bank model ready = !write → writes are accepted for 4 cycles. In the 5th cycle `wb_ready_o`=0, the read handshakes, and `stall_q[2]` clears.
- `StarveLimit`=0: the same stimulus leaves the read blocked indefinitely, and `wb_ready_o` stays 1.
- Async reset asserted mid-stream with `rr_q`=2 → pointer reads 0 immediately after reset. The next bank-0 contention between req0 and req3 grants req0.
